// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x4 active-low key matrix, debounces whole scan frames
// and reports the accepted key as a held code plus a one-clock press/repeat pulse.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   row_n[3:0] matrix rows, active-low, asynchronous to clk
//   col_n[3:0] column drive, one-hot active-low
//   key[4:0]   debounced held-key code {1'b1,row,col}, 5'h00 when none
//   key_pulse  held-key code for one clock on accepted press or repeat
module keypad_scan #(
    parameter int SCAN_DIV        = 2500,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [4:0] key,
    output logic [4:0] key_pulse
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);
    localparam logic [7:0] REP = 8'(REPEAT_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD,
        RELEASE
    } state_t;

    logic [3:0]    row_s1_q, row_s1_d;
    logic [3:0]    row_s2_q, row_s2_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [1:0]    col_q, col_d;
    logic [4:0]    best_q, best_d;
    state_t        state_q, state_d;
    logic [4:0]    cand_q, cand_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    rep_q, rep_d;
    logic [4:0]    key_q, key_d;
    logic [4:0]    pulse_q, pulse_d;

    logic       slot_end;
    logic       frame_end;
    logic [4:0] slot_code;
    logic [4:0] frame_code;

    // Scan timing and per-frame lowest-code tracking.
    always_comb begin
        row_s1_d  = row_n;
        row_s2_d  = row_s1_q;
        slot_end  = (slot_q == SLOT_LAST);
        frame_end = slot_end && (col_q == 2'd3);
        slot_d    = slot_end ? '0 : slot_q + SW'(1);
        col_d     = slot_end ? col_q + 2'd1 : col_q;

        // Lowest pressed row wins within the driven column.
        slot_code = 5'h00;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s2_q[r]) begin
                slot_code = {1'b1, r[1:0], col_q};
            end
        end

        // Include the current slot so the frame code is complete at frame end.
        frame_code = best_q;
        if (slot_code != 5'h00 &&
            (best_q == 5'h00 || slot_code < best_q)) begin
            frame_code = slot_code;
        end

        best_d = best_q;
        if (slot_end) begin
            best_d = frame_end ? 5'h00 : frame_code;
        end
    end

    // Debounce / repeat state machine, advanced once per frame.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        key_d   = key_q;
        pulse_d = 5'h00;

        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (frame_code != 5'h00) begin
                        state_d = CONFIRM;
                        cand_d  = frame_code;
                        cnt_d   = 4'd1;
                    end
                end
                CONFIRM: begin
                    if (frame_code == cand_q) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = HELD;
                            key_d   = cand_q;
                            pulse_d = cand_q;
                            rep_d   = 8'd0;
                        end
                    end else if (frame_code == 5'h00) begin
                        state_d = IDLE;
                    end else begin
                        cand_d = frame_code;
                        cnt_d  = 4'd1;
                    end
                end
                HELD: begin
                    if (frame_code == key_q) begin
                        // rep stays at zero when repeat is disabled.
                        if (REP != 8'd0) begin
                            if (rep_q + 8'd1 == REP) begin
                                pulse_d = key_q;
                                rep_d   = 8'd0;
                            end else begin
                                rep_d = rep_q + 8'd1;
                            end
                        end
                    end else begin
                        state_d = RELEASE;
                        cnt_d   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (frame_code == key_q) begin
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q + 4'd1 == DEB) begin
                            state_d = IDLE;
                            key_d   = 5'h00;
                            cnt_d   = 4'd0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q <= 4'hf;
            row_s2_q <= 4'hf;
            slot_q   <= '0;
            col_q    <= 2'd0;
            best_q   <= 5'h00;
            state_q  <= IDLE;
            cand_q   <= 5'h00;
            cnt_q    <= 4'd0;
            rep_q    <= 8'd0;
            key_q    <= 5'h00;
            pulse_q  <= 5'h00;
        end else begin
            row_s1_q <= row_s1_d;
            row_s2_q <= row_s2_d;
            slot_q   <= slot_d;
            col_q    <= col_d;
            best_q   <= best_d;
            state_q  <= state_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            rep_q    <= rep_d;
            key_q    <= key_d;
            pulse_q  <= pulse_d;
        end
    end

    assign col_n     = ~(4'b0001 << col_q);
    assign key       = key_q;
    assign key_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: drives a virtual 4x4 key matrix into two keypad_scan
// instances (repeat off / repeat every 2 frames) and checks them against a frame model.
module tb_keypad_scan;

    localparam int DEB = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n, col_n, row_n_r, col_n_r;
    logic [4:0] key, key_pulse, key_r, key_pulse_r;

    keypad_scan #(
        .SCAN_DIV(4), .DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(0)
    ) dut (
        .clk(clk), .rst(rst), .row_n(row_n), .col_n(col_n),
        .key(key), .key_pulse(key_pulse)
    );

    keypad_scan #(
        .SCAN_DIV(4), .DEBOUNCE_FRAMES(DEB), .REPEAT_FRAMES(2)
    ) dut_r (
        .clk(clk), .rst(rst), .row_n(row_n_r), .col_n(col_n_r),
        .key(key_r), .key_pulse(key_pulse_r)
    );

    always #5 clk = ~clk;

    // Pressed keys, bit index 4*row+col.
    logic [15:0] cur_mask = 16'h0000;

    function automatic logic [3:0] rows_for(input logic [15:0] m,
                                            input logic [3:0] cn);
        logic [3:0] rv;
        rv = 4'hf;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!cn[c] && m[4*r+c]) rv[r] = 1'b0;
        return rv;
    endfunction

    assign row_n   = rows_for(cur_mask, col_n);
    assign row_n_r = rows_for(cur_mask, col_n_r);

    // Lowest pressed index wins; code is 16+index.
    function automatic logic [4:0] fcode(input logic [15:0] m);
        logic [4:0] f;
        f = 5'h00;
        for (int i = 15; i >= 0; i--)
            if (m[i]) f = 5'(16 + i);
        return f;
    endfunction

    typedef struct {
        logic [4:0] key;
        logic [4:0] cand;
        int         run;
        int         away;
        int         since;
    } mdl_t;

    typedef struct {
        logic [15:0] mask;
        logic [4:0]  code;
    } vec_t;

    mdl_t       m[2];
    logic [4:0] ep[2];
    int         np[2];
    logic [4:0] last[2];
    int         checks = 0;
    int         errors = 0;
    int         ph = 0;
    vec_t       tbl[8];

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            m[i].key   = 5'h00;
            m[i].cand  = 5'h00;
            m[i].run   = 0;
            m[i].away  = 0;
            m[i].since = 0;
            ep[i]      = 5'h00;
        end
    endtask

    // One frame of the debounce rules: run = equal nonzero frames since idle,
    // away = frames without the held key, since = held frames since last pulse.
    task automatic mstep(input int i, input logic [4:0] f);
        int rep;
        rep   = (i == 1) ? 2 : 0;
        ep[i] = 5'h00;
        if (m[i].key == 5'h00) begin
            if (f == 5'h00) m[i].run = 0;
            else if (m[i].run > 0 && f == m[i].cand) m[i].run = m[i].run + 1;
            else begin
                m[i].cand = f;
                m[i].run  = 1;
            end
            if (m[i].run == DEB) begin
                m[i].key   = f;
                ep[i]      = f;
                m[i].since = 0;
                m[i].away  = 0;
                m[i].run   = 0;
            end
        end else if (f == m[i].key) begin
            if (m[i].away > 0) m[i].away = 0;
            else begin
                m[i].since = m[i].since + 1;
                if (rep != 0 && m[i].since == rep) begin
                    ep[i]      = m[i].key;
                    m[i].since = 0;
                end
            end
        end else begin
            m[i].away = m[i].away + 1;
            if (m[i].away == DEB) begin
                m[i].key  = 5'h00;
                m[i].away = 0;
                m[i].run  = 0;
            end
        end
    endtask

    task automatic tick();
        logic       fe;
        logic [3:0] ec;
        logic [4:0] kp[2];
        logic [4:0] kk[2];
        logic [3:0] cn[2];
        @(posedge clk);
        #1;
        ph++;
        fe = (ph % 16 == 0);
        if (fe) begin
            mstep(0, fcode(cur_mask));
            mstep(1, fcode(cur_mask));
        end
        ec    = ~(4'b0001 << ((ph / 4) % 4));
        kp[0] = key_pulse;
        kp[1] = key_pulse_r;
        kk[0] = key;
        kk[1] = key_r;
        cn[0] = col_n;
        cn[1] = col_n_r;
        for (int i = 0; i < 2; i++) begin
            chk("col_n", 16'(cn[i]), 16'(ec));
            chk("key", 16'(kk[i]), 16'(m[i].key));
            chk("key_pulse", 16'(kp[i]), fe ? 16'(ep[i]) : 16'h0);
            if (kp[i] != 5'h00) begin
                np[i]++;
                last[i] = kp[i];
            end
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) tick();
    endtask

    task automatic clr_cnt();
        for (int i = 0; i < 2; i++) begin
            np[i]   = 0;
            last[i] = 5'h00;
        end
    endtask

    // Entered #1 after a clock edge; releases #1 after a later edge.
    task automatic do_reset();
        rst = 1'b0;
        #2;
        chk("rst_col_n", 16'(col_n), 16'he);
        chk("rst_key", 16'(key), 16'h0);
        chk("rst_pulse", 16'(key_pulse), 16'h0);
        chk("rst_key_r", 16'(key_r), 16'h0);
        @(posedge clk);
        #1;
        chk("rst_col_n_hold", 16'(col_n_r), 16'he);
        chk("rst_pulse_hold", 16'(key_pulse_r), 16'h0);
        rst = 1'b1;
        ph  = 0;
        mreset();
        clr_cnt();
    endtask

    initial begin
        tbl[0] = '{16'h4000, 5'h1e};
        tbl[1] = '{16'h6000, 5'h1d};
        tbl[2] = '{16'h0001, 5'h10};
        tbl[3] = '{16'h8000, 5'h1f};
        tbl[4] = '{16'h8421, 5'h10};
        tbl[5] = '{16'h0480, 5'h17};
        tbl[6] = '{16'h0300, 5'h18};
        tbl[7] = '{16'h0000, 5'h00};

        mreset();
        clr_cnt();
        #1;
        do_reset();

        // Column walk after reset.
        frames(2);

        // Single key held, then released.
        cur_mask = 16'h4000;
        frames(5);
        chk("hold_npulse", 16'(np[0]), 16'd1);
        chk("hold_code", 16'(last[0]), 16'h1e);
        chk("hold_key", 16'(key), 16'h1e);
        clr_cnt();
        cur_mask = 16'h0000;
        frames(2);
        chk("rel_key_early", 16'(key), 16'h1e);
        frames(1);
        chk("rel_key", 16'(key), 16'h0);
        chk("rel_npulse", 16'(np[0]), 16'd0);

        // Table of single/multi-key presses.
        for (int e = 0; e < 8; e++) begin
            cur_mask = 16'h0000;
            frames(4);
            clr_cnt();
            cur_mask = tbl[e].mask;
            frames(4);
            chk("tbl_code", 16'(last[0]), 16'(tbl[e].code));
            chk("tbl_npulse", 16'(np[0]), 16'(tbl[e].code != 5'h00));
            chk("tbl_key", 16'(key), 16'(tbl[e].code));
        end

        // Bounce: toggles every 8 clocks.
        cur_mask = 16'h0000;
        frames(4);
        clr_cnt();
        repeat (5) begin
            cur_mask = 16'h4000;
            repeat (8) tick();
            cur_mask = 16'h0000;
            repeat (8) tick();
        end
        chk("bounce_npulse", 16'(np[0]), 16'd0);
        chk("bounce_key", 16'(key), 16'h0);

        // Auto-repeat on the REPEAT_FRAMES=2 instance.
        do_reset();
        cur_mask = 16'h2000;
        frames(3);
        chk("rep_accept", 16'(np[1]), 16'd1);
        chk("rep_accept_code", 16'(last[1]), 16'h1d);
        clr_cnt();
        frames(10);
        chk("rep_npulse", 16'(np[1]), 16'd5);
        chk("rep_code", 16'(last[1]), 16'h1d);
        chk("norep_npulse", 16'(np[0]), 16'd0);

        // Reset during CONFIRM aborts the debounce.
        cur_mask = 16'h0000;
        frames(4);
        cur_mask = 16'h4000;
        frames(2);
        repeat (5) tick();
        do_reset();
        frames(2);
        chk("rstc_npulse_2f", 16'(np[0]), 16'd0);
        frames(1);
        chk("rstc_npulse_3f", 16'(np[0]), 16'd1);
        chk("rstc_code", 16'(last[0]), 16'h1e);

        // Random frame-level stimulus against the model.
        do_reset();
        for (int f = 0; f < 150; f++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel >= 4 && sel <= 5) cur_mask = 16'h0000;
            else if (sel >= 6 && sel <= 8)
                cur_mask = 16'h0001 << $urandom_range(0, 15);
            else if (sel == 9)
                cur_mask = (16'h0001 << $urandom_range(0, 15)) |
                           (16'h0001 << $urandom_range(0, 15));
            frames(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
